// File: rtl/hwpe_stream_package.sv
// Shared types and helpers for HWPE stream arbitration blocks.
package hwpe_stream_package;

    localparam int unsigned ARB_FLAGS_OWNER_WIDTH = 8;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                             busy;
        logic [ARB_FLAGS_OWNER_WIDTH-1:0] owner;
    } flags_arb_t;

    // Index width for a set of nb requesters, never narrower than one bit.
    function automatic int unsigned arb_id_width(input int unsigned nb);
        if (nb > 32'd1) begin
            return 32'($clog2(nb));
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle carrying data plus byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start_i, wrapping.
module hwpe_stream_rr_pick #(
    parameter int unsigned NB_IN    = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NB_IN-1:0]    req_i,
    input  logic [ID_WIDTH-1:0] start_i,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                found_o
);

    // Walk once around the ring from start_i; the first requester seen wins.
    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            cand = ID_WIDTH'((32'(start_i) + i) % NB_IN);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_sidech_arbiter.sv
// Round-robin N:1 stream arbiter feeding a FIFO, exporting the winner index as side channel.
// Define HWPE_STREAM_SIDECH_ARB_BURST_EN to keep a grant for up to MAX_BURST beats.
module hwpe_stream_sidech_arbiter
    import hwpe_stream_package::*;
#(
    parameter  int unsigned NB_IN      = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned ID_WIDTH   = arb_id_width(NB_IN)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   enable_i,
    hwpe_stream_intf_stream.sink   push_i [NB_IN-1:0],
    hwpe_stream_intf_stream.source pop_o,
    output logic [ID_WIDTH-1:0]    sidech_o,
    output logic [NB_IN-1:0]       grant_o,
    output logic                   busy_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_BURST + 1);
`ifdef HWPE_STREAM_SIDECH_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;

    logic [NB_IN-1:0]      push_valid_s;
    logic [DATA_WIDTH-1:0] push_data_s [NB_IN];
    logic [STRB_WIDTH-1:0] push_strb_s [NB_IN];
    logic [NB_IN-1:0]      ready_vec_s;

    logic [ID_WIDTH-1:0]   pick_idx_s;
    logic                  pick_found_s;
    logic                  has_win_s;
    logic [ID_WIDTH-1:0]   win_s;
    logic                  pop_ready_s;
    logic                  pop_valid_s;
    logic [DATA_WIDTH-1:0] pop_data_s;
    logic [STRB_WIDTH-1:0] pop_strb_s;
    logic [ID_WIDTH-1:0]   sidech_s;
    logic [NB_IN-1:0]      grant_s;

    function automatic logic [ID_WIDTH-1:0] ptr_next(input logic [ID_WIDTH-1:0] idx);
        if (32'(idx) >= NB_IN - 32'd1) begin
            return '0;
        end else begin
            return ID_WIDTH'(32'(idx) + 32'd1);
        end
    endfunction

    for (genvar k = 0; k < NB_IN; k++) begin : gen_unpack
        assign push_valid_s[k] = push_i[k].valid;
        assign push_data_s[k]  = push_i[k].data;
        assign push_strb_s[k]  = push_i[k].strb;
        assign push_i[k].ready = ready_vec_s[k];
    end

    assign pop_ready_s = pop_o.ready;
    assign pop_o.valid = pop_valid_s;
    assign pop_o.data  = pop_data_s;
    assign pop_o.strb  = pop_strb_s;
    assign sidech_o    = sidech_s;
    assign grant_o     = grant_s;
    assign busy_o      = (state_q == HOLD);

    hwpe_stream_rr_pick #(
        .NB_IN    (NB_IN),
        .ID_WIDTH (ID_WIDTH)
    ) i_rr_pick (
        .req_i   (push_valid_s),
        .start_i (rr_ptr_q),
        .idx_o   (pick_idx_s),
        .found_o (pick_found_s)
    );

    // Winner selection; no handshake can be offered while reset or clear is pending.
    always_comb begin
        has_win_s = 1'b0;
        win_s     = '0;
        if (!rst_ni || clear_i) begin
            has_win_s = 1'b0;
        end else if (state_q == HOLD) begin
            has_win_s = 1'b1;
            win_s     = owner_q;
        end else if (enable_i && pick_found_s) begin
            has_win_s = 1'b1;
            win_s     = pick_idx_s;
        end else begin
            has_win_s = 1'b0;
        end
    end

    // Data mux and single-hot ready/grant steering.
    always_comb begin
        pop_valid_s = 1'b0;
        pop_data_s  = '0;
        pop_strb_s  = '0;
        sidech_s    = '0;
        grant_s     = '0;
        ready_vec_s = '0;
        if (has_win_s) begin
            pop_valid_s        = push_valid_s[win_s];
            pop_data_s         = push_data_s[win_s];
            pop_strb_s         = push_strb_s[win_s];
            sidech_s           = push_valid_s[win_s] ? win_s : '0;
            grant_s[win_s]     = 1'b1;
            ready_vec_s[win_s] = pop_ready_s;
        end else begin
            pop_valid_s = 1'b0;
        end
    end

    // Grant lifecycle: lock on stall or burst, release to the next requester in ring order.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        cnt_inc_s   = burst_cnt_q + CNT_WIDTH'(1);
        case (state_q)
            ARB: begin
                if (has_win_s && pop_valid_s && !pop_ready_s) begin
                    state_d     = HOLD;
                    owner_d     = win_s;
                    burst_cnt_d = '0;
                end else if (has_win_s && pop_valid_s && BURST_EN && (MAX_BURST > 32'd1)) begin
                    state_d     = HOLD;
                    owner_d     = win_s;
                    burst_cnt_d = CNT_WIDTH'(1);
                end else if (has_win_s && pop_valid_s) begin
                    rr_ptr_d = ptr_next(win_s);
                end else begin
                    state_d = ARB;
                end
            end
            HOLD: begin
                if (!push_valid_s[owner_q]) begin
                    state_d     = ARB;
                    rr_ptr_d    = ptr_next(owner_q);
                    burst_cnt_d = '0;
                end else if (pop_ready_s) begin
                    if (!BURST_EN || (cnt_inc_s >= CNT_WIDTH'(MAX_BURST))) begin
                        state_d     = ARB;
                        rr_ptr_d    = ptr_next(owner_q);
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = cnt_inc_s;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = ARB;
                owner_d     = '0;
                rr_ptr_d    = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset and soft clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else if (clear_i) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_sidech_arbiter.sv
// Directed plus randomized bench for hwpe_stream_sidech_arbiter against a grant/quota model.
module tb_hwpe_stream_sidech_arbiter;

    localparam int NB  = 4;
    localparam int MAXB = 4;
`ifdef HWPE_STREAM_SIDECH_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        enable;
    logic        pop_ready;
    logic [3:0]  v;
    logic [31:0] d [NB];
    logic [3:0]  s [NB];
    logic [3:0]  rdy;
    logic [1:0]  sidech;
    logic [3:0]  grant;
    logic        busy;

    int errors;
    int checks;
    int m_lock;   // requester currently holding the grant, -1 if free
    int m_ptr;    // where the next free search starts
    int m_left;   // handshakes left in the current grant
    int fair_exp [8];

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if [3:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

    for (genvar k = 0; k < NB; k++) begin : gen_drv
        assign push_if[k].valid = v[k];
        assign push_if[k].data  = d[k];
        assign push_if[k].strb  = s[k];
        assign rdy[k]           = push_if[k].ready;
    end
    assign pop_if.ready = pop_ready;

    hwpe_stream_sidech_arbiter #(
        .NB_IN      (4),
        .DATA_WIDTH (32),
        .MAX_BURST  (4)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .enable_i (enable),
        .push_i   (push_if),
        .pop_o    (pop_if),
        .sidech_o (sidech),
        .grant_o  (grant),
        .busy_o   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (!rst_n || clear) return -1;
        if (m_lock >= 0) return m_lock;
        if (!enable) return -1;
        for (int i = 0; i < NB; i++) begin
            if (v[(m_ptr + i) % NB]) return (m_ptr + i) % NB;
        end
        return -1;
    endfunction

    function automatic void model_update();
        int w;
        int quota;
        quota = BURST ? MAXB : 1;
        w = model_winner();
        if (!rst_n || clear) begin
            m_lock = -1; m_ptr = 0; m_left = 0;
            return;
        end
        if (w < 0) return;
        if (!v[w]) begin
            m_lock = -1; m_ptr = (w + 1) % NB; m_left = 0;
            return;
        end
        if (pop_ready) begin
            if (m_lock < 0) m_left = quota;
            m_left--;
            if (m_left == 0) begin
                m_lock = -1; m_ptr = (w + 1) % NB;
            end else begin
                m_lock = w;
            end
        end else if (m_lock < 0) begin
            m_lock = w; m_left = quota;
        end
    endfunction

    task automatic new_data();
        for (int k = 0; k < NB; k++) begin
            d[k] = $urandom;
            s[k] = 4'($urandom_range(0, 15));
        end
    endtask

    // Compare every output against the model mid-cycle, away from the clock edge.
    task automatic check_now(input string tag);
        int w;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_strb;
        logic [3:0]  e_grant;
        logic [3:0]  e_rdy;
        logic [1:0]  e_side;
        @(negedge clk);
        w = model_winner();
        e_valid = 1'b0; e_data = 32'd0; e_strb = 4'd0; e_grant = 4'd0; e_rdy = 4'd0; e_side = 2'd0;
        if (w >= 0) begin
            e_valid    = v[w];
            e_data     = d[w];
            e_strb     = s[w];
            e_grant[w] = 1'b1;
            e_rdy[w]   = pop_ready;
            e_side     = v[w] ? 2'(w) : 2'd0;
        end
        check({tag, ".valid"},  32'(pop_if.valid), 32'(e_valid));
        check({tag, ".data"},   pop_if.data,       e_data);
        check({tag, ".strb"},   32'(pop_if.strb),  32'(e_strb));
        check({tag, ".sidech"}, 32'(sidech),       32'(e_side));
        check({tag, ".grant"},  32'(grant),        32'(e_grant));
        check({tag, ".ready"},  32'(rdy),          32'(e_rdy));
        check({tag, ".busy"},   32'(busy),         32'(m_lock >= 0));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
        new_data();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        check_now("clr");
        advance();
        clear = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        m_lock = -1; m_ptr = 0; m_left = 0;
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; pop_ready = 1'b1; v = 4'hF;
        new_data();
`ifdef HWPE_STREAM_SIDECH_ARB_BURST_EN
        fair_exp = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

        // Reset held two cycles with every requester valid.
        for (int i = 0; i < 2; i++) begin
            check_now("rst");
            check("rst.grant0", 32'(grant), 32'd0);
            check("rst.valid0", 32'(pop_if.valid), 32'd0);
            advance();
        end
        rst_n = 1'b1;
        check_now("rel");
        check("rel.first_side", 32'(sidech), 32'd0);
        check("rel.first_hs", 32'(pop_if.valid && rdy[0]), 32'd1);
        advance();

        // Fairness / burst sequence from a cleared pointer.
        do_clear();
        for (int i = 0; i < 8; i++) begin
            check_now("fair");
            check("fair.seq", 32'(sidech), 32'(fair_exp[i]));
            advance();
        end

        // Stall with requesters 1 and 2 valid.
        do_clear();
        v = 4'b0110; pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_now("stall");
            check("stall.grant", 32'(grant), 32'h2);
            advance();
        end
        check("stall.busy", 32'(busy), 32'd1);
        pop_ready = 1'b1;
        check_now("stall.rel");
        check("stall.beat", 32'(sidech), 32'd1);
        advance();
        check_now("stall.next");
`ifdef HWPE_STREAM_SIDECH_ARB_BURST_EN
        check("stall.next_grant", 32'(grant), 32'h2);
`else
        check("stall.next_grant", 32'(grant), 32'h4);
`endif
        advance();

        // Sparse wrap: move pointer to 1, then only requester 3, then only 0.
        do_clear();
        v = 4'b0001;
        check_now("sparse.a"); advance();
        v = 4'b1000;
        for (int i = 0; i < 3; i++) begin check_now("sparse.b"); advance(); end
        v = 4'b0001;
        for (int i = 0; i < 3; i++) begin check_now("sparse.c"); advance(); end

        // Requester 1 drops valid partway through its turn.
        do_clear();
        v = 4'hF;
        for (int i = 0; i < 6; i++) begin check_now("drop.a"); advance(); end
        v = 4'b1101;
        for (int i = 0; i < 2; i++) begin check_now("drop.b"); advance(); end

        // Clear while requester 2 is stalled.
        do_clear();
        v = 4'b0100; pop_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin check_now("cst.a"); advance(); end
        v = 4'b0101; clear = 1'b1;
        check_now("cst.clr"); advance();
        clear = 1'b0;
        check_now("cst.after");
        check("cst.grant0", 32'(grant), 32'h1);
        check("cst.notbusy", 32'(busy), 32'd0);
        advance();

        // Enable low in ARB: nothing granted.
        pop_ready = 1'b1;
        do_clear();
        enable = 1'b0; v = 4'hF;
        for (int i = 0; i < 2; i++) begin
            check_now("en0");
            check("en0.ready", 32'(rdy), 32'd0);
            advance();
        end
        enable = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            v         = 4'($urandom_range(0, 15));
            pop_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 31) == 0);
            check_now("rand");
            advance();
        end
        clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
